agp_master_engine: RTL and testbench
====================================

AGP_MASTER_ENGINE -- requirements
Module: agp_master_engine

Interface
REQ-001 SHALL have parameters: ADDR_W, default 29, quad-word address width; DEPTH, default 8, entries per queue (power of two, >=2); PRIO_EN, default 1, high-priority command support (0 = all requests low priority).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge; rst  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: req_valid in 1 request offered; req_ready out 1 request accepted this cycle; req_write in 1 write(1)/read(0); req_prio in 1 high priority; req_addr in ADDR_W quad-word address; req_wdata in 64 write data.
REQ-004 SHALL have ports: rd_valid out 1 read data available; rd_ready in 1 consumer pops; rd_data out 64 read data head.
REQ-005 SHALL have ports: gnt_n in 1 grant; st in 3 grant status; req_n out 1 bus request; pipe_n out 1 pipelined address phase; ad_o out 32; ad_oe out 1; ad_i in 32; c_be_o out 4; c_be_oe out 1; irdy_n out 1; trdy_n in 1.

Function
REQ-006 Request queue (RQ) SHALL hold {write, prio, addr}; write data queue (WDQ) 64-bit; read return queue (RDQ) 64-bit; each DEPTH entries with log2(DEPTH)+1-bit pointers, full = MSBs differ and low bits equal, empty = pointers equal; wrap modulo DEPTH.
REQ-007 req_ready SHALL be 1 when RQ not full and (req_write=0 or WDQ not full); on req_valid&req_ready the entry (and data for writes) SHALL be written same edge.
REQ-008 req_n SHALL be 0 whenever RQ non-empty and FSM in IDLE or ADDR; else 1.
REQ-009 Read credit: a read SHALL NOT be issued unless outstanding_reads + RDQ count < DEPTH; blocked head read stalls RQ (in-order issue).
REQ-010 st SHALL be sampled only on cycles with gnt_n=0; codes: 111 start address, 000/001 read low/high, 010/011 write low/high, 110 idle; others treated as idle.
REQ-011 FSM states: IDLE, ADDR, RD_LO, RD_HI, WR_LO, WR_HI.
REQ-012 IDLE/ADDR + gnt_n=0, st=111, RQ head issuable: next cycle pipe_n=0, ad_o={addr,3'b000}, c_be_o = read-low 0000, read-high 0001, write-low 0100, write-high 0101, ad_oe=c_be_oe=1, RQ pops, state ADDR; with PRIO_EN=0 prio bit forced 0.
REQ-013 ADDR with RQ empty or head blocked: pipe_n=1, ad_oe=c_be_oe=0, state IDLE; one request per cycle while pipe_n=0.
REQ-014 gnt_n=0, st=000/001 and outstanding_reads>0: state RD_LO; capture ad_i as low word on first cycle with trdy_n=0; RD_HI captures next cycle's ad_i as high word, pushes {hi,lo} to RDQ, decrements outstanding_reads, returns IDLE.
REQ-015 gnt_n=0, st=010/011 and WDQ non-empty: WR_LO drives ad_o=WDQ head[31:0], c_be_o=1111, irdy_n=0; advance to WR_HI when trdy_n=0; WR_HI drives [63:32], irdy_n=0; on trdy_n=0 pops WDQ, irdy_n=1, ad_oe=0, state IDLE.
REQ-016 Read/write status with nothing outstanding SHALL set sticky error flag err (out 1) and stay IDLE.
REQ-017 rd_valid = RDQ non-empty; rd_data = head; pop on rd_valid&rd_ready; simultaneous push and pop SHALL both take effect, count unchanged.
REQ-018 Data phases SHALL NOT be preempted: st changes during RD_*/WR_* ignored until IDLE.
REQ-019 High/low priority SHALL share queues; ordering strictly FIFO.

Reset
REQ-020 rst=0 at rising edge SHALL empty all queues, clear outstanding_reads and err, FSM=IDLE, req_n=1, pipe_n=1, irdy_n=1, ad_oe=c_be_oe=0, ad_o=0, c_be_o=0, req_ready=0 during reset, rd_valid=0.
REQ-021 Reset mid-transfer SHALL abort immediately; partial read word discarded; no queue content survives.

Structure
REQ-022 Shared package agp_pkg SHALL hold st codes, c_be command codes, FSM state encoding.
REQ-023 One sub-module agp_sync_fifo (parametrised width/depth, push/pop/full/empty/count) SHALL be instanced three times.

Verification
REQ-024 Reset, enqueue read 0x1 then write 0x3/0xFF; grant st=111 two cycles -> pipe_n=0 with ad_o=0x8,c_be=0000 then ad_o=0x18,c_be=0100, then pipe_n=1.
REQ-025 After read issued, st=000, trdy_n=0, ad_i=0x11111111 then 0x22222222 -> rd_data=0x2222222211111111, rd_valid=1.
REQ-026 Write 0xFE0 queued, st=010, trdy_n held 1 two cycles then 0 -> ad_o=0x00000FE0 held stable, then 0x00000000, irdy_n=1 after, WDQ empty.
REQ-027 Enqueue DEPTH reads, no returns -> req_ready=0 at DEPTH, 9th request blocked; RDQ full with rd_ready=0 blocks further read issue.
REQ-028 Assert rst=0 in RD_HI -> next cycle all outputs at reset values, rd_valid=0.
REQ-029 st=010 with WDQ empty -> err=1, FSM IDLE.

Source files
------------

// File: rtl/agp_pkg.sv
// Shared AGP master constants: grant status codes, C/BE# command codes and
// the engine FSM state encoding.
package agp_pkg;

    localparam logic [2:0] ST_RD_LO = 3'b000;
    localparam logic [2:0] ST_RD_HI = 3'b001;
    localparam logic [2:0] ST_WR_LO = 3'b010;
    localparam logic [2:0] ST_WR_HI = 3'b011;
    localparam logic [2:0] ST_IDLE  = 3'b110;
    localparam logic [2:0] ST_ADDR  = 3'b111;

    localparam logic [3:0] CBE_RD_LO = 4'b0000;
    localparam logic [3:0] CBE_RD_HI = 4'b0001;
    localparam logic [3:0] CBE_WR_LO = 4'b0100;
    localparam logic [3:0] CBE_WR_HI = 4'b0101;
    localparam logic [3:0] CBE_DATA  = 4'b1111;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_RD_LO = 3'd2;
    localparam logic [2:0] S_RD_HI = 3'd3;
    localparam logic [2:0] S_WR_LO = 3'd4;
    localparam logic [2:0] S_WR_HI = 3'd5;

    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_ADDR = 2'd1,
        K_RD   = 2'd2,
        K_WR   = 2'd3
    } st_kind_t;

    // Reserved status codes collapse onto "no action".
    function automatic st_kind_t st_decode(input logic [2:0] st);
        case (st)
            ST_ADDR:            return K_ADDR;
            ST_RD_LO, ST_RD_HI: return K_RD;
            ST_WR_LO, ST_WR_HI: return K_WR;
            ST_IDLE:            return K_NONE;
            default:            return K_NONE;
        endcase
    endfunction

    function automatic logic [3:0] cbe_cmd(input logic write, input logic prio);
        case ({write, prio})
            2'b00:   return CBE_RD_LO;
            2'b01:   return CBE_RD_HI;
            2'b10:   return CBE_WR_LO;
            default: return CBE_WR_HI;
        endcase
    endfunction

endpackage

// File: rtl/agp_master_engine_if.sv
// Host request/return handshakes and AGP bus pins of the master engine.
interface agp_master_engine_if #(
    parameter int ADDR_W = 29
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_prio;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;

    logic              rd_valid;
    logic              rd_ready;
    logic [63:0]       rd_data;

    logic              gnt_n;
    logic [2:0]        st;
    logic              req_n;
    logic              pipe_n;
    logic [31:0]       ad_o;
    logic              ad_oe;
    logic [31:0]       ad_i;
    logic [3:0]        c_be_o;
    logic              c_be_oe;
    logic              irdy_n;
    logic              trdy_n;
    logic              err;

    modport master (
        input  req_valid, req_write, req_prio, req_addr, req_wdata,
        output req_ready,
        output rd_valid, rd_data,
        input  rd_ready,
        input  gnt_n, st, ad_i, trdy_n,
        output req_n, pipe_n, ad_o, ad_oe, c_be_o, c_be_oe, irdy_n, err
    );

    modport slave (
        output req_valid, req_write, req_prio, req_addr, req_wdata,
        input  req_ready,
        input  rd_valid, rd_data,
        output rd_ready,
        output gnt_n, st, ad_i, trdy_n,
        input  req_n, pipe_n, ad_o, ad_oe, c_be_o, c_be_oe, irdy_n, err
    );
endinterface

// File: rtl/agp_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; storage is not reset, only the
// pointers are, so a reset leaves the queue logically empty.
module agp_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign o_count = r_wptr - r_rptr;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/agp_master_engine.sv
// AGP master engine: queues host requests, issues pipelined addresses under
// grant status, and runs 64-bit read/write data phases over the 32-bit AD bus.
module agp_master_engine
    import agp_pkg::*;
#(
    parameter int ADDR_W  = 29,
    parameter int DEPTH   = 8,
    parameter int PRIO_EN = 1
) (
    input logic                 clk,
    input logic                 rst,
    agp_master_engine_if.master bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int RQW = ADDR_W + 2;

    logic [RQW-1:0]    w_rq_din;
    logic [RQW-1:0]    w_rq_dout;
    logic              w_rq_push, w_rq_pop, w_rq_full, w_rq_empty;
    logic [AW:0]       w_rq_count;
    logic [63:0]       w_wdq_dout;
    logic              w_wdq_push, w_wdq_pop, w_wdq_full, w_wdq_empty;
    logic [AW:0]       w_wdq_count;
    logic [63:0]       w_rdq_din;
    logic [63:0]       w_rdq_dout;
    logic              w_rdq_push, w_rdq_pop, w_rdq_full, w_rdq_empty;
    logic [AW:0]       w_rdq_count;
    logic              w_unused;

    logic              w_req_ready;
    logic              w_head_write;
    logic              w_head_prio;
    logic [ADDR_W-1:0] w_head_addr;
    logic              w_credit_ok;
    logic              w_head_ok;
    logic              w_in_arb;
    logic              w_issue;
    st_kind_t          w_kind;

    logic [2:0]        r_state;
    logic [AW:0]       r_outstanding;
    logic              r_err;
    logic              r_pipe_n;
    logic              r_ad_oe;
    logic              r_cbe_oe;
    logic              r_irdy_n;
    logic [31:0]       r_ad_o;
    logic [3:0]        r_cbe_o;
    logic [31:0]       r_lo;

    assign w_req_ready = rst && !w_rq_full && (!bus.req_write || !w_wdq_full);
    assign w_rq_push   = bus.req_valid && w_req_ready;
    assign w_wdq_push  = w_rq_push && bus.req_write;
    assign w_rq_din    = {bus.req_write, (PRIO_EN != 0) && bus.req_prio, bus.req_addr};

    assign w_head_write = w_rq_dout[ADDR_W+1];
    assign w_head_prio  = w_rq_dout[ADDR_W];
    assign w_head_addr  = w_rq_dout[ADDR_W-1:0];

    // Reads only go out when a return slot is guaranteed in the RDQ.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_rdq_count}) < (AW+2)'(DEPTH);
    assign w_head_ok   = !w_rq_empty && (w_head_write || w_credit_ok);
    assign w_kind      = bus.gnt_n ? K_NONE : st_decode(bus.st);
    assign w_in_arb    = (r_state == S_IDLE) || (r_state == S_ADDR);
    assign w_issue     = w_in_arb && (w_kind == K_ADDR) && w_head_ok;
    assign w_rq_pop    = w_issue;
    assign w_wdq_pop   = (r_state == S_WR_HI) && !bus.trdy_n;
    assign w_rdq_push  = (r_state == S_RD_HI);
    assign w_rdq_din   = {bus.ad_i, r_lo};
    assign w_rdq_pop   = bus.rd_ready;
    assign w_unused    = ^{w_rq_count, w_wdq_count, w_rdq_full};

    agp_sync_fifo #(.WIDTH(RQW), .DEPTH(DEPTH)) u_rq (
        .clk(clk), .rst(rst), .i_push(w_rq_push), .i_wdata(w_rq_din), .i_pop(w_rq_pop),
        .o_rdata(w_rq_dout), .o_full(w_rq_full), .o_empty(w_rq_empty), .o_count(w_rq_count)
    );

    agp_sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_wdq (
        .clk(clk), .rst(rst), .i_push(w_wdq_push), .i_wdata(bus.req_wdata), .i_pop(w_wdq_pop),
        .o_rdata(w_wdq_dout), .o_full(w_wdq_full), .o_empty(w_wdq_empty), .o_count(w_wdq_count)
    );

    agp_sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_rdq (
        .clk(clk), .rst(rst), .i_push(w_rdq_push), .i_wdata(w_rdq_din), .i_pop(w_rdq_pop),
        .o_rdata(w_rdq_dout), .o_full(w_rdq_full), .o_empty(w_rdq_empty), .o_count(w_rdq_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            r_pipe_n      <= 1'b1;
            r_ad_oe       <= 1'b0;
            r_cbe_oe      <= 1'b0;
            r_irdy_n      <= 1'b1;
            r_ad_o        <= '0;
            r_cbe_o       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ADDR: begin
                    r_state  <= S_IDLE;
                    r_pipe_n <= 1'b1;
                    r_ad_oe  <= 1'b0;
                    r_cbe_oe <= 1'b0;
                    r_ad_o   <= '0;
                    r_cbe_o  <= '0;
                    if (w_issue) begin
                        r_state  <= S_ADDR;
                        r_pipe_n <= 1'b0;
                        r_ad_oe  <= 1'b1;
                        r_cbe_oe <= 1'b1;
                        r_ad_o   <= 32'({w_head_addr, 3'b000});
                        r_cbe_o  <= cbe_cmd(w_head_write, w_head_prio);
                        if (!w_head_write) r_outstanding <= r_outstanding + (AW+1)'(1);
                    end else if (w_kind == K_RD) begin
                        if (r_outstanding != '0) r_state <= S_RD_LO;
                        else                     r_err   <= 1'b1;
                    end else if (w_kind == K_WR) begin
                        if (!w_wdq_empty) begin
                            r_state  <= S_WR_LO;
                            r_ad_oe  <= 1'b1;
                            r_cbe_oe <= 1'b1;
                            r_ad_o   <= w_wdq_dout[31:0];
                            r_cbe_o  <= CBE_DATA;
                            r_irdy_n <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RD_LO: if (!bus.trdy_n) r_state <= S_RD_HI;
                S_RD_HI: begin
                    r_outstanding <= r_outstanding - (AW+1)'(1);
                    r_state       <= S_IDLE;
                end
                S_WR_LO: if (!bus.trdy_n) begin
                    r_ad_o  <= w_wdq_dout[63:32];
                    r_state <= S_WR_HI;
                end
                S_WR_HI: if (!bus.trdy_n) begin
                    r_irdy_n <= 1'b1;
                    r_ad_oe  <= 1'b0;
                    r_cbe_oe <= 1'b0;
                    r_ad_o   <= '0;
                    r_cbe_o  <= '0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Low read word is pure data; a reset discards it by leaving RD_HI.
    always_ff @(posedge clk) begin
        if (r_state == S_RD_LO && !bus.trdy_n) r_lo <= bus.ad_i;
    end

    assign bus.req_ready = w_req_ready;
    assign bus.req_n     = !(rst && !w_rq_empty && w_in_arb);
    assign bus.pipe_n    = r_pipe_n;
    assign bus.ad_o      = r_ad_o;
    assign bus.ad_oe     = r_ad_oe;
    assign bus.c_be_o    = r_cbe_o;
    assign bus.c_be_oe   = r_cbe_oe;
    assign bus.irdy_n    = r_irdy_n;
    assign bus.err       = r_err;
    assign bus.rd_valid  = !w_rdq_empty;
    assign bus.rd_data   = w_rdq_dout;

endmodule

// File: tb/tb_agp_master_engine.sv
// Directed bench for agp_master_engine: a queue-level model is compared with
// the DUT every cycle, plus literal spot checks on key bus values.
module tb_agp_master_engine;
    localparam int ADDR_W  = 29;
    localparam int DEPTH   = 8;
    localparam int PRIO_EN = 1;

    localparam int M_IDLE = 0, M_ADDR = 1, M_RD_LO = 2, M_RD_HI = 3, M_WR_LO = 4, M_WR_HI = 5;

    typedef struct packed {
        logic              w;
        logic              p;
        logic [ADDR_W-1:0] a;
    } rq_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    agp_master_engine_if #(.ADDR_W(ADDR_W)) bus ();

    agp_master_engine #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PRIO_EN(PRIO_EN)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    rq_t         m_rq[$];
    logic [63:0] m_wdq[$];
    logic [63:0] m_rdq[$];
    int          m_out;
    int          m_phase;
    logic        m_err;
    logic [31:0] m_lo;
    logic        e_pipe_n, e_ad_oe, e_cbe_oe, e_irdy_n;
    logic [31:0] e_ad;
    logic [3:0]  e_cbe;
    bit          armed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_ready();
        return rst && (m_rq.size() < DEPTH) && (!bus.req_write || m_wdq.size() < DEPTH);
    endfunction

    function automatic logic exp_req_n();
        return !(rst && m_rq.size() != 0 && (m_phase == M_IDLE || m_phase == M_ADDR));
    endfunction

    task automatic bus_release();
        e_pipe_n = 1'b1; e_ad_oe = 1'b0; e_cbe_oe = 1'b0; e_ad = '0; e_cbe = '0;
    endtask

    // Advance the model by one clock using the inputs the DUT will sample.
    task automatic model_step();
        bit  acc, pop, ad_st, rd_st, wr_st;
        rq_t h;
        if (!rst) begin
            m_rq.delete(); m_wdq.delete(); m_rdq.delete();
            m_out = 0; m_phase = M_IDLE; m_err = 1'b0; e_irdy_n = 1'b1;
            bus_release();
            armed = 1;
            return;
        end
        acc   = bus.req_valid && exp_ready();
        pop   = bus.rd_ready && m_rdq.size() != 0;
        ad_st = !bus.gnt_n && bus.st == 3'b111;
        rd_st = !bus.gnt_n && bus.st[2:1] == 2'b00;
        wr_st = !bus.gnt_n && bus.st[2:1] == 2'b01;
        case (m_phase)
            M_IDLE, M_ADDR: begin
                bus_release();
                m_phase = M_IDLE;
                if (ad_st && m_rq.size() != 0 && (m_rq[0].w || (m_out + m_rdq.size()) < DEPTH)) begin
                    h = m_rq.pop_front();
                    e_pipe_n = 1'b0; e_ad_oe = 1'b1; e_cbe_oe = 1'b1;
                    e_ad = {h.a, 3'b000};
                    e_cbe = {1'b0, h.w, 1'b0, h.p};
                    m_phase = M_ADDR;
                    if (!h.w) m_out++;
                end else if (rd_st) begin
                    if (m_out > 0) m_phase = M_RD_LO; else m_err = 1'b1;
                end else if (wr_st) begin
                    if (m_wdq.size() != 0) begin
                        m_phase = M_WR_LO;
                        e_ad = m_wdq[0][31:0]; e_cbe = 4'hF;
                        e_ad_oe = 1'b1; e_cbe_oe = 1'b1; e_irdy_n = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            M_RD_LO: if (!bus.trdy_n) begin m_lo = bus.ad_i; m_phase = M_RD_HI; end
            M_RD_HI: begin
                m_rdq.push_back({bus.ad_i, m_lo});
                m_out--;
                m_phase = M_IDLE;
            end
            M_WR_LO: if (!bus.trdy_n) begin e_ad = m_wdq[0][63:32]; m_phase = M_WR_HI; end
            M_WR_HI: if (!bus.trdy_n) begin
                void'(m_wdq.pop_front());
                bus_release();
                e_irdy_n = 1'b1;
                m_phase = M_IDLE;
            end
            default: m_phase = M_IDLE;
        endcase
        if (pop) void'(m_rdq.pop_front());
        if (acc) begin
            m_rq.push_back('{w: bus.req_write, p: (PRIO_EN != 0) && bus.req_prio, a: bus.req_addr});
            if (bus.req_write) m_wdq.push_back(bus.req_wdata);
        end
    endtask

    task automatic check_cycle();
        logic [127:0] a, e;
        logic         ev;
        ev = (m_rdq.size() != 0);
        a = {20'd0, bus.req_ready, bus.req_n, bus.pipe_n, bus.ad_oe, bus.c_be_oe, bus.irdy_n,
             bus.rd_valid, bus.err, bus.c_be_o, bus.ad_o, (bus.rd_valid ? bus.rd_data : 64'd0)};
        e = {20'd0, exp_ready(), exp_req_n(), e_pipe_n, e_ad_oe, e_cbe_oe, e_irdy_n,
             ev, m_err, e_cbe, e_ad, (ev ? m_rdq[0] : 64'd0)};
        chk("cycle_compare", a, e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (armed) check_cycle();
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic w, input logic p, input logic [ADDR_W-1:0] a, input logic [63:0] d);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_prio = p; bus.req_addr = a; bus.req_wdata = d;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic grant(input logic [2:0] s);
        bus.gnt_n = 1'b0; bus.st = s;
    endtask

    task automatic ungrant();
        bus.gnt_n = 1'b1; bus.st = 3'b110;
    endtask

    initial begin
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_prio = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rd_ready = 1'b0;
        bus.gnt_n = 1'b1; bus.st = 3'b110; bus.ad_i = '0; bus.trdy_n = 1'b1;
        repeat (2) tick();
        chk("rst_req_n", bus.req_n, 1'b1);
        chk("rst_pipe_n", bus.pipe_n, 1'b1);
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_ad_oe", {bus.ad_oe, bus.c_be_oe, bus.irdy_n, bus.rd_valid}, 4'b0010);
        rst = 1'b1;

        // Address phases: read 0x1 then write 0x3.
        enq(1'b0, 1'b0, 29'h1, 64'd0);
        chk("req_n_pending", bus.req_n, 1'b0);
        enq(1'b1, 1'b0, 29'h3, 64'hFF);
        grant(3'b111);
        tick();
        chk("addr_rd", {bus.pipe_n, bus.c_be_o, bus.ad_o}, {1'b0, 4'b0000, 32'h8});
        tick();
        chk("addr_wr", {bus.pipe_n, bus.c_be_o, bus.ad_o}, {1'b0, 4'b0100, 32'h18});
        ungrant();
        tick();
        chk("addr_end", {bus.pipe_n, bus.ad_oe}, 2'b10);

        // Read return.
        grant(3'b000);
        tick();
        ungrant(); bus.trdy_n = 1'b0; bus.ad_i = 32'h11111111;
        tick();
        bus.trdy_n = 1'b1; bus.ad_i = 32'h22222222;
        tick();
        chk("rd_data", {bus.rd_valid, bus.rd_data}, {1'b1, 64'h2222222211111111});
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("rd_popped", bus.rd_valid, 1'b0);

        // Write data 0xFF, no wait states.
        grant(3'b010);
        tick();
        chk("wr_lo_ff", {bus.irdy_n, bus.c_be_o, bus.ad_o}, {1'b0, 4'hF, 32'hFF});
        ungrant(); bus.trdy_n = 1'b0;
        tick();
        tick();
        bus.trdy_n = 1'b1;
        chk("wr_done_ff", bus.irdy_n, 1'b1);

        // High-priority write 0xFE0 with two wait states.
        enq(1'b1, 1'b1, 29'h10, 64'hFE0);
        grant(3'b111);
        tick();
        chk("addr_wr_hi", {bus.c_be_o, bus.ad_o}, {4'b0101, 32'h80});
        grant(3'b010);
        tick();
        ungrant();
        chk("wr_lo_0", {bus.irdy_n, bus.ad_o}, {1'b0, 32'h00000FE0});
        tick();
        chk("wr_lo_1", {bus.irdy_n, bus.ad_o}, {1'b0, 32'h00000FE0});
        tick();
        chk("wr_lo_2", {bus.irdy_n, bus.ad_o}, {1'b0, 32'h00000FE0});
        bus.trdy_n = 1'b0;
        tick();
        chk("wr_hi", {bus.irdy_n, bus.ad_oe, bus.ad_o}, {1'b0, 1'b1, 32'h0});
        tick();
        chk("wr_end", {bus.irdy_n, bus.ad_oe}, 2'b10);
        bus.trdy_n = 1'b1;

        // Write status with empty WDQ.
        chk("err_before", bus.err, 1'b0);
        grant(3'b010);
        tick();
        ungrant();
        chk("err_set", {bus.err, bus.ad_oe, bus.irdy_n}, 3'b101);

        // Fill RQ with DEPTH reads.
        for (int i = 0; i < DEPTH; i++) begin
            bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_prio = i[0];
            bus.req_addr = 29'h100 + 29'(i);
            tick();
        end
        bus.req_addr = 29'h1FF;
        #1;
        chk("rq_full_ready", bus.req_ready, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        grant(3'b111);
        repeat (DEPTH) tick();
        ungrant();
        enq(1'b0, 1'b0, 29'h1FF, 64'd0);
        grant(3'b111);
        repeat (2) tick();
        chk("credit_out_block", {bus.pipe_n, bus.req_n}, 2'b10);
        ungrant();
        for (int i = 0; i < DEPTH; i++) begin
            grant(3'b001);
            tick();
            ungrant(); bus.trdy_n = 1'b0; bus.ad_i = 32'hA0000000 + 32'(i);
            tick();
            bus.trdy_n = 1'b1; bus.ad_i = 32'hB0000000 + 32'(i);
            tick();
        end
        chk("rdq_head0", bus.rd_data, 64'hB0000000_A0000000);
        grant(3'b111);
        repeat (2) tick();
        chk("credit_rdq_block", bus.pipe_n, 1'b1);
        ungrant();
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("rdq_head1", bus.rd_data, 64'hB0000001_A0000001);
        grant(3'b111);
        tick();
        chk("credit_freed", {bus.pipe_n, bus.c_be_o, bus.ad_o}, {1'b0, 4'b0000, 32'h00000FF8});
        ungrant();
        bus.rd_ready = 1'b1;
        repeat (3) tick();
        bus.rd_ready = 1'b0;

        // Reset in the middle of a read data phase.
        grant(3'b000);
        tick();
        ungrant(); bus.trdy_n = 1'b0; bus.ad_i = 32'hDEADBEEF;
        tick();
        rst = 1'b0; bus.trdy_n = 1'b1;
        tick();
        chk("mid_rst_outs", {bus.req_n, bus.pipe_n, bus.irdy_n, bus.ad_oe, bus.c_be_oe,
                             bus.rd_valid, bus.err, bus.req_ready}, 8'b11100000);
        chk("mid_rst_bus", {bus.c_be_o, bus.ad_o}, 36'd0);
        rst = 1'b1;
        tick();
        grant(3'b000);
        tick();
        ungrant();
        chk("rd_none_err", bus.err, 1'b1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
